booth_vote_arbiter: RTL and testbench
=====================================

// Module: booth_vote_arbiter
// PURPOSE
//   Shares one Secure_VotingMachine among N voting booths. Arbitrates booth requests round-robin and
//   grants one booth at a time. Drives the machine's ENABLE/VOTE_IN with a clean single-cycle vote
//   pulse, enforces a per-voter timeout, and gates ADMIN_RESET behind a key check with lockout.
//   Sits between the booth front-ends and the voting machine in the top-level.
// PARAMETERS
//   N_BOOTH      4      number of booths (2..8)
//   TIMEOUT_CYC  16     max cycles a granted booth may hold the machine without voting
//   KEY_W        8      admin key width
//   ADMIN_KEY    8'hA5  key required for an admin clear
//   MAX_FAILS    3      wrong-key attempts before sticky lockout
//   TOTAL_W      8      width of the ballots-issued counter
// PORTS
//   CLK            in   1            system clock; all logic on posedge
//   RESET          in   1            synchronous, active-high reset
//   SESSION_OPEN   in   1            polling session active; no new grants while low
//   BOOTH_REQ      in   N_BOOTH      level request per booth (voter authenticated at booth)
//   BOOTH_VOTE     in   2*N_BOOTH    booth i vote code in [2i+1:2i]; 00=none, 01=A, 10=B, 11=C
//   BOOTH_GNT      out  N_BOOTH      one-hot grant, registered
//   BOOTH_DONE     out  N_BOOTH      1-cycle pulse to the booth whose vote was issued
//   TIMEOUT_PULSE  out  1            1-cycle pulse when a grant is abandoned by timeout
//   VM_ENABLE      out  1            to voting machine ENABLE
//   VM_VOTE_IN     out  2            to voting machine VOTE_IN
//   VM_ADMIN_RESET out  1            to voting machine ADMIN_RESET (1-cycle pulse)
//   ADMIN_REQ      in   1            admin clear request (sampled in IDLE only)
//   ADMIN_KEY_IN   in   KEY_W        key presented with ADMIN_REQ
//   KEY_FAIL       out  1            1-cycle pulse on wrong key
//   LOCKED         out  1            sticky after MAX_FAILS wrong keys; cleared only by RESET
//   BALLOT_TOTAL   out  TOTAL_W      ballots issued since RESET/admin clear; saturates at all-ones
//   ARB_STATE      out  3            current FSM state (debug)
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, rr pointer=0, fail count=0, timer=0.
//   States: IDLE(0) GRANT(1) WAIT_VOTE(2) ISSUE(3) RELEASE(4) CLEAR(5).
//   IDLE: priority ADMIN_REQ > booth requests.
//     ADMIN_REQ & !LOCKED & key match -> CLEAR. ADMIN_REQ & mismatch -> KEY_FAIL pulse, fails++,
//     stay IDLE; fails==MAX_FAILS -> LOCKED=1. ADMIN_REQ while LOCKED: ignored, no pulse.
//     else SESSION_OPEN & |BOOTH_REQ -> winner w = first requester at or after rr pointer -> GRANT.
//   GRANT (1 cycle): BOOTH_GNT[w]=1, VM_ENABLE=1, timer=0 -> WAIT_VOTE.
//   WAIT_VOTE: GNT/VM_ENABLE held; VM_VOTE_IN=00; timer++ each cycle.
//     vote slice of w != 00 -> latch code -> ISSUE (checked first).
//     else BOOTH_REQ[w]==0 or SESSION_OPEN==0 -> RELEASE, no vote.
//     else timer==TIMEOUT_CYC-1 -> TIMEOUT_PULSE=1 -> RELEASE.
//   ISSUE (1 cycle): VM_ENABLE=1, VM_VOTE_IN=latched code, BOOTH_DONE[w]=1, BALLOT_TOTAL++
//     (saturating) -> RELEASE. Completes even if session closes this cycle.
//   RELEASE (1 cycle): GNT=0, VM_ENABLE=0, VM_VOTE_IN=00, rr pointer=(w+1) mod N_BOOTH -> IDLE.
//     Guarantees the machine sees VOTE_IN return to 00 and ENABLE drop between voters.
//   CLEAR (1 cycle): VM_ADMIN_RESET=1, BALLOT_TOTAL=0, fails=0 -> IDLE.
//   Latency: request in IDLE -> GNT 1 cycle later; vote seen -> VM_VOTE_IN next cycle;
//     minimum 4 cycles per voter (GRANT, WAIT_VOTE, ISSUE, RELEASE).
//   A booth holding REQ after DONE is re-granted only after the other requesters have had a turn.
//   RESET mid-operation: immediate return to reset values; any latched vote is discarded.
// STRUCTURE
//   Package vote_pkg: state encodings, vote codes (VOTE_NONE/A/B/C).
//   Sub-module rr_arbiter (N_BOOTH requests + pointer -> one-hot/index winner, combinational).
//   Top holds FSM, timer, vote latch, fail counter, total counter.
// TESTING
//   Single booth: REQ[0]=1, vote 01 two cycles after GNT -> one VM_VOTE_IN=01 pulse,
//     DONE[0] pulse, TOTAL=1.
//   Round-robin: REQ=4'b1111 held, each booth votes -> grant order 0,1,2,3,0; no double GNT.
//   Timeout: grant booth 2, never vote -> TIMEOUT_PULSE after 16 WAIT_VOTE cycles,
//     no VM_VOTE_IN, TOTAL unchanged.
//   Admin: key A5 in IDLE -> VM_ADMIN_RESET 1 cycle, TOTAL=0; three wrong keys -> 3 KEY_FAIL,
//     LOCKED=1, then correct key ignored.
//   Session close in WAIT_VOTE -> RELEASE with no vote; SESSION_OPEN=0 with REQ -> no GNT.
//   RESET asserted during ISSUE -> all outputs 0 next cycle, TOTAL=0.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared encodings for the booth arbiter: FSM state values and the two-bit vote codes.
package vote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_WAIT_VOTE = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_CLEAR     = 3'd5
  } arb_state_t;

  localparam logic [1:0] VOTE_NONE = 2'b00;
  localparam logic [1:0] VOTE_A    = 2'b01;
  localparam logic [1:0] VOTE_B    = 2'b10;
  localparam logic [1:0] VOTE_C    = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, as index and one-hot.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  logic [IDX_W-1:0] cand [N];

  // cand[k] is the booth examined k places after the pointer
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = IDX_W'((32'(ptr) + gi) % N);
  end

  // Walk from the farthest candidate back so the nearest one wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign onehot[gi] = valid && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/booth_vote_arbiter.sv
// Shares one voting machine among several booths: round-robin grants, clean vote pulses,
// per-voter timeout and key-gated admin clear with sticky lockout.
module booth_vote_arbiter
  import vote_pkg::*;
#(
  parameter int                N_BOOTH     = 4,
  parameter int                TIMEOUT_CYC = 16,
  parameter int                KEY_W       = 8,
  parameter logic [KEY_W-1:0]  ADMIN_KEY   = 8'hA5,
  parameter int                MAX_FAILS   = 3,
  parameter int                TOTAL_W     = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SESSION_OPEN,
  input  logic [N_BOOTH-1:0]     BOOTH_REQ,
  input  logic [2*N_BOOTH-1:0]   BOOTH_VOTE,
  output logic [N_BOOTH-1:0]     BOOTH_GNT,
  output logic [N_BOOTH-1:0]     BOOTH_DONE,
  output logic                   TIMEOUT_PULSE,
  output logic                   VM_ENABLE,
  output logic [1:0]             VM_VOTE_IN,
  output logic                   VM_ADMIN_RESET,
  input  logic                   ADMIN_REQ,
  input  logic [KEY_W-1:0]       ADMIN_KEY_IN,
  output logic                   KEY_FAIL,
  output logic                   LOCKED,
  output logic [TOTAL_W-1:0]     BALLOT_TOTAL,
  output logic [2:0]             ARB_STATE
);

  localparam int IDX_W  = $clog2(N_BOOTH);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  arb_state_t        state_reg;
  logic [IDX_W-1:0]  w_idx_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [FAIL_W-1:0] fail_cnt_reg;

  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  logic [N_BOOTH-1:0] arb_onehot;
  logic [1:0]         cur_vote;
  logic [IDX_W-1:0]   rr_next;

  rr_arbiter #(.N(N_BOOTH), .IDX_W(IDX_W)) u_rr (
    .req    (BOOTH_REQ),
    .ptr    (rr_ptr_reg),
    .valid  (arb_valid),
    .idx    (arb_idx),
    .onehot (arb_onehot)
  );

  assign cur_vote  = BOOTH_VOTE[{w_idx_reg, 1'b0} +: 2];
  assign rr_next   = (w_idx_reg == IDX_W'(N_BOOTH - 1)) ? '0 : w_idx_reg + 1'b1;
  assign ARB_STATE = state_reg;

  // Outputs are set on entry to the state in which they must be visible
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      w_idx_reg      <= '0;
      rr_ptr_reg     <= '0;
      timer_reg      <= '0;
      fail_cnt_reg   <= '0;
      BOOTH_GNT      <= '0;
      BOOTH_DONE     <= '0;
      TIMEOUT_PULSE  <= 1'b0;
      VM_ENABLE      <= 1'b0;
      VM_VOTE_IN     <= VOTE_NONE;
      VM_ADMIN_RESET <= 1'b0;
      KEY_FAIL       <= 1'b0;
      LOCKED         <= 1'b0;
      BALLOT_TOTAL   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          KEY_FAIL <= 1'b0;
          if (ADMIN_REQ && !LOCKED) begin
            if (ADMIN_KEY_IN == ADMIN_KEY) begin
              state_reg      <= ST_CLEAR;
              VM_ADMIN_RESET <= 1'b1;
              BALLOT_TOTAL   <= '0;
              fail_cnt_reg   <= '0;
            end else begin
              KEY_FAIL     <= 1'b1;
              fail_cnt_reg <= fail_cnt_reg + 1'b1;
              if (fail_cnt_reg == FAIL_W'(MAX_FAILS - 1)) LOCKED <= 1'b1;
            end
          end else if (SESSION_OPEN && arb_valid) begin
            state_reg <= ST_GRANT;
            w_idx_reg <= arb_idx;
            BOOTH_GNT <= arb_onehot;
            VM_ENABLE <= 1'b1;
            timer_reg <= '0;
          end
        end
        ST_GRANT: begin
          state_reg <= ST_WAIT_VOTE;
          timer_reg <= '0;
        end
        ST_WAIT_VOTE: begin
          timer_reg <= timer_reg + 1'b1;
          if (cur_vote != VOTE_NONE) begin
            state_reg  <= ST_ISSUE;
            VM_VOTE_IN <= cur_vote;
            BOOTH_DONE <= BOOTH_GNT;
            if (BALLOT_TOTAL != {TOTAL_W{1'b1}}) BALLOT_TOTAL <= BALLOT_TOTAL + 1'b1;
          end else if (!BOOTH_REQ[w_idx_reg] || !SESSION_OPEN) begin
            state_reg <= ST_RELEASE;
            BOOTH_GNT <= '0;
            VM_ENABLE <= 1'b0;
          end else if (timer_reg == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_reg     <= ST_RELEASE;
            TIMEOUT_PULSE <= 1'b1;
            BOOTH_GNT     <= '0;
            VM_ENABLE     <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_reg  <= ST_RELEASE;
          BOOTH_GNT  <= '0;
          VM_ENABLE  <= 1'b0;
          VM_VOTE_IN <= VOTE_NONE;
          BOOTH_DONE <= '0;
        end
        ST_RELEASE: begin
          state_reg     <= ST_IDLE;
          rr_ptr_reg    <= rr_next;
          TIMEOUT_PULSE <= 1'b0;
        end
        ST_CLEAR: begin
          state_reg      <= ST_IDLE;
          VM_ADMIN_RESET <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_vote_arbiter.sv
// Directed bench for booth_vote_arbiter: reset, single vote, round-robin, timeout, admin, session close.
module tb_booth_vote_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SESSION_OPEN;
  logic [3:0] BOOTH_REQ;
  logic [7:0] BOOTH_VOTE;
  logic [3:0] BOOTH_GNT;
  logic [3:0] BOOTH_DONE;
  logic       TIMEOUT_PULSE;
  logic       VM_ENABLE;
  logic [1:0] VM_VOTE_IN;
  logic       VM_ADMIN_RESET;
  logic       ADMIN_REQ;
  logic [7:0] ADMIN_KEY_IN;
  logic       KEY_FAIL;
  logic       LOCKED;
  logic [7:0] BALLOT_TOTAL;
  logic [2:0] ARB_STATE;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 CLK = ~CLK;

  booth_vote_arbiter dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .SESSION_OPEN   (SESSION_OPEN),
    .BOOTH_REQ      (BOOTH_REQ),
    .BOOTH_VOTE     (BOOTH_VOTE),
    .BOOTH_GNT      (BOOTH_GNT),
    .BOOTH_DONE     (BOOTH_DONE),
    .TIMEOUT_PULSE  (TIMEOUT_PULSE),
    .VM_ENABLE      (VM_ENABLE),
    .VM_VOTE_IN     (VM_VOTE_IN),
    .VM_ADMIN_RESET (VM_ADMIN_RESET),
    .ADMIN_REQ      (ADMIN_REQ),
    .ADMIN_KEY_IN   (ADMIN_KEY_IN),
    .KEY_FAIL       (KEY_FAIL),
    .LOCKED         (LOCKED),
    .BALLOT_TOTAL   (BALLOT_TOTAL),
    .ARB_STATE      (ARB_STATE)
  );

  wire [25:0] all_outs = {BOOTH_GNT, BOOTH_DONE, TIMEOUT_PULSE, VM_ENABLE, VM_VOTE_IN,
                          VM_ADMIN_RESET, KEY_FAIL, LOCKED, BALLOT_TOTAL, ARB_STATE};

  // Advance one clock; outputs are then stable for sampling and inputs may change.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; SESSION_OPEN = 1'b0; BOOTH_REQ = '0; BOOTH_VOTE = '0;
    ADMIN_REQ = 1'b0; ADMIN_KEY_IN = '0;
    tick(); tick();
    total_cnt++;
    if (all_outs !== 26'd0) begin
      $display("FAIL reset_outputs: got %h want 0", all_outs); bad_cnt++;
    end
    RESET = 1'b0;
    tick();
    total_cnt++;
    if (ARB_STATE !== 3'd0 || BOOTH_GNT !== 4'b0) begin
      $display("FAIL reset_idle: state=%0d gnt=%b want state=0 gnt=0000", ARB_STATE, BOOTH_GNT); bad_cnt++;
    end
    $display("test_reset: done");
  endtask

  task automatic test_single_booth();
    SESSION_OPEN = 1'b1; BOOTH_REQ = 4'b0001;
    tick();
    total_cnt++;
    if (BOOTH_GNT !== 4'b0001 || VM_ENABLE !== 1'b1 || ARB_STATE !== 3'd1) begin
      $display("FAIL single_grant: gnt=%b en=%b state=%0d want 0001 1 1", BOOTH_GNT, VM_ENABLE, ARB_STATE); bad_cnt++;
    end
    tick();
    total_cnt++;
    if (ARB_STATE !== 3'd2 || BOOTH_GNT !== 4'b0001 || VM_VOTE_IN !== 2'b00) begin
      $display("FAIL single_wait: state=%0d gnt=%b vote=%b want 2 0001 00", ARB_STATE, BOOTH_GNT, VM_VOTE_IN); bad_cnt++;
    end
    BOOTH_VOTE = 8'b0000_0001;
    tick();
    total_cnt++;
    if (VM_VOTE_IN !== 2'b01 || BOOTH_DONE !== 4'b0001 || BALLOT_TOTAL !== 8'd1 || VM_ENABLE !== 1'b1) begin
      $display("FAIL single_issue: vote=%b done=%b total=%0d en=%b want 01 0001 1 1",
               VM_VOTE_IN, BOOTH_DONE, BALLOT_TOTAL, VM_ENABLE); bad_cnt++;
    end
    BOOTH_VOTE = '0; BOOTH_REQ = '0;
    tick();
    total_cnt++;
    if (ARB_STATE !== 3'd4 || BOOTH_GNT !== 4'b0 || VM_ENABLE !== 1'b0 || VM_VOTE_IN !== 2'b00 || BOOTH_DONE !== 4'b0) begin
      $display("FAIL single_release: state=%0d gnt=%b en=%b vote=%b done=%b want 4 0000 0 00 0000",
               ARB_STATE, BOOTH_GNT, VM_ENABLE, VM_VOTE_IN, BOOTH_DONE); bad_cnt++;
    end
    tick();
    total_cnt++;
    if (ARB_STATE !== 3'd0 || BALLOT_TOTAL !== 8'd1) begin
      $display("FAIL single_idle: state=%0d total=%0d want 0 1", ARB_STATE, BALLOT_TOTAL); bad_cnt++;
    end
    $display("test_single_booth: booth 0 voted A");
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_gnt;
    test_reset();
    SESSION_OPEN = 1'b1; BOOTH_REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_gnt = 4'b0001 << exp_order[i];
      tick();
      total_cnt++;
      if (BOOTH_GNT !== exp_gnt) begin
        $display("FAIL rr_grant_%0d: gnt=%b want %b", i, BOOTH_GNT, exp_gnt); bad_cnt++;
      end
      tick();
      BOOTH_VOTE = 8'b10 << (2 * exp_order[i]);
      tick();
      total_cnt++;
      if (BOOTH_DONE !== exp_gnt || VM_VOTE_IN !== 2'b10) begin
        $display("FAIL rr_done_%0d: done=%b vote=%b want %b 10", i, BOOTH_DONE, VM_VOTE_IN, exp_gnt); bad_cnt++;
      end
      BOOTH_VOTE = '0;
      tick();
      total_cnt++;
      if (BOOTH_GNT !== 4'b0 || VM_ENABLE !== 1'b0) begin
        $display("FAIL rr_release_%0d: gnt=%b en=%b want 0000 0", i, BOOTH_GNT, VM_ENABLE); bad_cnt++;
      end
      tick();
      $display("test_round_robin: grant %0d to booth %0d", i, exp_order[i]);
    end
    total_cnt++;
    if (BALLOT_TOTAL !== 8'd5) begin
      $display("FAIL rr_total: total=%0d want 5", BALLOT_TOTAL); bad_cnt++;
    end
  endtask

  task automatic test_timeout();
    bit early_pulse = 0;
    bit vote_seen   = 0;
    bit left_wait   = 0;
    BOOTH_REQ = 4'b0100;
    tick();
    total_cnt++;
    if (BOOTH_GNT !== 4'b0100) begin
      $display("FAIL to_grant: gnt=%b want 0100", BOOTH_GNT); bad_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (TIMEOUT_PULSE !== 1'b0) early_pulse = 1;
      if (VM_VOTE_IN !== 2'b00) vote_seen = 1;
      if (ARB_STATE !== 3'd2) left_wait = 1;
    end
    total_cnt++;
    if (early_pulse || vote_seen || left_wait) begin
      $display("FAIL to_wait_window: early=%0d vote=%0d left=%0d want 0 0 0", early_pulse, vote_seen, left_wait); bad_cnt++;
    end
    tick();
    total_cnt++;
    if (TIMEOUT_PULSE !== 1'b1 || ARB_STATE !== 3'd4 || BOOTH_GNT !== 4'b0 || VM_VOTE_IN !== 2'b00 || BALLOT_TOTAL !== 8'd5) begin
      $display("FAIL to_pulse: pulse=%b state=%0d gnt=%b vote=%b total=%0d want 1 4 0000 00 5",
               TIMEOUT_PULSE, ARB_STATE, BOOTH_GNT, VM_VOTE_IN, BALLOT_TOTAL); bad_cnt++;
    end
    BOOTH_REQ = '0;
    tick();
    total_cnt++;
    if (TIMEOUT_PULSE !== 1'b0 || ARB_STATE !== 3'd0) begin
      $display("FAIL to_after: pulse=%b state=%0d want 0 0", TIMEOUT_PULSE, ARB_STATE); bad_cnt++;
    end
    $display("test_timeout: booth 2 abandoned");
  endtask

  task automatic test_admin();
    ADMIN_REQ = 1'b1; ADMIN_KEY_IN = 8'hA5;
    tick();
    total_cnt++;
    if (VM_ADMIN_RESET !== 1'b1 || BALLOT_TOTAL !== 8'd0 || ARB_STATE !== 3'd5) begin
      $display("FAIL admin_clear: ar=%b total=%0d state=%0d want 1 0 5", VM_ADMIN_RESET, BALLOT_TOTAL, ARB_STATE); bad_cnt++;
    end
    ADMIN_REQ = 1'b0;
    tick();
    total_cnt++;
    if (VM_ADMIN_RESET !== 1'b0 || ARB_STATE !== 3'd0) begin
      $display("FAIL admin_pulse_end: ar=%b state=%0d want 0 0", VM_ADMIN_RESET, ARB_STATE); bad_cnt++;
    end
    ADMIN_REQ = 1'b1; ADMIN_KEY_IN = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (KEY_FAIL !== 1'b1 || LOCKED !== (i == 2) || ARB_STATE !== 3'd0) begin
        $display("FAIL admin_badkey_%0d: kf=%b locked=%b state=%0d want 1 %0d 0", i, KEY_FAIL, LOCKED, ARB_STATE, (i == 2)); bad_cnt++;
      end
    end
    ADMIN_KEY_IN = 8'hA5;
    tick();
    total_cnt++;
    if (KEY_FAIL !== 1'b0 || VM_ADMIN_RESET !== 1'b0 || ARB_STATE !== 3'd0 || LOCKED !== 1'b1) begin
      $display("FAIL admin_locked: kf=%b ar=%b state=%0d locked=%b want 0 0 0 1", KEY_FAIL, VM_ADMIN_RESET, ARB_STATE, LOCKED); bad_cnt++;
    end
    ADMIN_REQ = 1'b0;
    $display("test_admin: clear then lockout");
  endtask

  task automatic test_session_close();
    bit granted = 0;
    SESSION_OPEN = 1'b1; BOOTH_REQ = 4'b0010;
    tick();
    total_cnt++;
    if (BOOTH_GNT !== 4'b0010) begin
      $display("FAIL sc_grant: gnt=%b want 0010", BOOTH_GNT); bad_cnt++;
    end
    tick();
    SESSION_OPEN = 1'b0;
    tick();
    total_cnt++;
    if (ARB_STATE !== 3'd4 || BOOTH_GNT !== 4'b0 || BOOTH_DONE !== 4'b0 || TIMEOUT_PULSE !== 1'b0 || BALLOT_TOTAL !== 8'd0) begin
      $display("FAIL sc_release: state=%0d gnt=%b done=%b to=%b total=%0d want 4 0000 0000 0 0",
               ARB_STATE, BOOTH_GNT, BOOTH_DONE, TIMEOUT_PULSE, BALLOT_TOTAL); bad_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (BOOTH_GNT !== 4'b0 || ARB_STATE !== 3'd0) granted = 1;
    end
    total_cnt++;
    if (granted) begin
      $display("FAIL sc_closed_nogrant: grant seen with session closed, want none"); bad_cnt++;
    end
    BOOTH_REQ = '0;
    $display("test_session_close: released without vote");
  endtask

  task automatic test_back_to_back_reset();
    SESSION_OPEN = 1'b1; BOOTH_REQ = 4'b0001;
    tick();
    tick();
    BOOTH_VOTE = 8'b0000_0011;
    tick();
    total_cnt++;
    if (ARB_STATE !== 3'd3 || VM_VOTE_IN !== 2'b11 || BALLOT_TOTAL !== 8'd1 || BOOTH_DONE !== 4'b0001) begin
      $display("FAIL rst_pre_issue: state=%0d vote=%b total=%0d done=%b want 3 11 1 0001",
               ARB_STATE, VM_VOTE_IN, BALLOT_TOTAL, BOOTH_DONE); bad_cnt++;
    end
    RESET = 1'b1;
    tick();
    total_cnt++;
    if (all_outs !== 26'd0) begin
      $display("FAIL rst_in_issue: outputs=%h want 0", all_outs); bad_cnt++;
    end
    RESET = 1'b0; BOOTH_VOTE = '0; BOOTH_REQ = '0; SESSION_OPEN = 1'b0;
    tick();
    $display("test_back_to_back_reset: reset during issue");
  endtask

  initial begin
    test_reset();
    test_single_booth();
    test_round_robin();
    test_timeout();
    test_admin();
    test_session_close();
    test_back_to_back_reset();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
